// File: rtl/if_pc_unit.sv
// Fetch-stage program counter: picks the next fetch address from sequential,
// branch, exception and exception-return sources, and holds one redirect across a stall.
module if_pc_unit #(
  parameter int unsigned    XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h0000_3000),
  parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(32'h0000_4180),
  parameter int unsigned    INST_BYTES  = 4,
  parameter bit             ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            redir_pending,
  output logic            if_adel
);

  localparam logic [XLEN-1:0] STEP        = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] EXC_RESUME  = EXC_VEC + STEP;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_q;

  // Next-PC selection; exceptions and returns bypass the stall entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_VEC;
      pend_q <= '0;
      state  <= IDLE;
    end else if (exc_req) begin
      pc_q  <= EXC_RESUME;
      state <= IDLE;
    end else if (eret_req) begin
      pc_q  <= epc;
      state <= IDLE;
    end else if (stall) begin
      if (br_valid) begin
        pend_q <= br_target;
        state  <= PEND;
      end
    end else if (br_valid) begin
      pc_q  <= br_target;
      state <= IDLE;
    end else if (state == PEND) begin
      pc_q  <= pend_q;
      state <= IDLE;
    end else begin
      pc_q <= pc_q + STEP;
    end
  end

  // The handler is fetched in the same cycle the exception is taken.
  always_comb begin
    pc = pc_q;
    if (reset) begin
      pc = RESET_VEC;
    end else if (exc_req) begin
      pc = EXC_VEC;
    end
  end

  assign pc_valid      = ~reset;
  assign redir_pending = (state == PEND) && !reset;

  generate
    if (ALIGN_CHECK) begin : g_align
      assign if_adel = |pc[1:0];
    end else begin : g_no_align
      assign if_adel = 1'b0;
    end
  endgenerate

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
- Parametrised fetch-stage program counter: the next generation of the single-width IF PC register.
- Generates the next PC internally from these sources: sequential increment, branch/jump redirect, exception vector, and exception return (EPC).
- Buffers a redirect that arrives while the pipeline is stalled, and flags misaligned fetch addresses.
- Sits at the head of the IF stage and drives the instruction-memory address and the IF/ID PC field.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_3000, PC value loaded by reset
EXC_VEC, 32'h0000_4180, exception handler entry address
INST_BYTES, 4, sequential increment step
ALIGN_CHECK, 1, 1 = drive if_adel on misaligned PC; 0 = if_adel tied 0

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
stall  input  1  1 = hold PC (hazard or memory back-pressure)
br_valid  input  1  ID-stage branch/jump taken this cycle
br_target  input  XLEN  redirect target qualified by br_valid
exc_req  input  1  exception/interrupt accepted by CP0 this cycle
eret_req  input  1  exception return accepted this cycle
epc  input  XLEN  return address qualified by eret_req
pc  output  XLEN  PC of the instruction fetched this cycle
pc_valid  output  1  0 while reset is high, 1 otherwise
redir_pending  output  1  a buffered redirect is waiting for stall to drop
if_adel  output  1  fetch address misaligned: pc[1:0] != 0 and ALIGN_CHECK = 1

Behaviour:
- Registers:
  - pc_q (XLEN)
  - pend_q (XLEN)
  - state (IDLE / PEND)
- Reset values:
  - pc_q = RESET_VEC, state = IDLE, pend_q = 0.
  - While reset is high, pc = RESET_VEC, pc_valid = 0, redir_pending = 0, and if_adel follows pc.
- Combinational pc output:
  - pc = EXC_VEC when exc_req && !reset; otherwise pc = pc_q.
  - reset has top priority.
  - An exception therefore fetches the handler in the same cycle.
- Next-PC priority, evaluated each posedge with reset low (highest first):
  1. exc_req: pc_q <= EXC_VEC + INST_BYTES; state <= IDLE. Ignores stall and clears any pending redirect.
  2. eret_req: pc_q <= epc; state <= IDLE. Ignores stall and clears pending.
  3. stall && br_valid: pc_q held; pend_q <= br_target; state <= PEND. A newer target overwrites an older buffered one.
  4. stall: pc_q held, state unchanged.
  5. br_valid (not stalled): pc_q <= br_target; state <= IDLE. A live redirect supersedes a buffered one.
  6. state = PEND (not stalled): pc_q <= pend_q; state <= IDLE.
  7. Otherwise: pc_q <= pc_q + INST_BYTES.
- State machine:
  - IDLE -> PEND only via rule 3.
  - PEND -> IDLE via rule 1, 2, 5 or 6.
  - PEND with stall held and no br_valid remains PEND.
- redir_pending = (state == PEND) && !reset.
- Arithmetic:
  - The increment is modulo 2^XLEN; PC wraps from all-ones to 0 silently.
  - Targets are taken verbatim; no alignment masking is applied.
- exc_req and eret_req together: exc_req wins.
- Latency:
  - Redirects are visible on pc one cycle after acceptance.
  - Exceptions are visible on pc in the same cycle.
- Reset mid-operation, including in PEND: the next cycle returns to the reset values; the buffered target is lost.

Test Plan:
- Reset release, no stall, 4 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_valid goes 0 to 1 after reset falls.
- br_valid = 1 with br_target = 0x3400 at pc = 0x3008 -> next pc = 0x3400, then 0x3404.
- stall = 1 for 3 cycles; br_target 0x3500 in cycle 1, then 0x3600 in cycle 2 -> pc held and redir_pending = 1; after stall drops, pc = 0x3600 and redir_pending = 0.
- exc_req pulse while stalled in PEND, pc_q = 0x3010 -> pc = 0x4180 in the same cycle, 0x4184 next cycle, redir_pending cleared; then eret_req with epc = 0x3010 -> pc = 0x3010 next cycle.
- exc_req && eret_req together, then reset asserted while in PEND -> exception wins (pc = 0x4180 immediately, then 0x4184); after reset, pc = 0x3000 and state = IDLE.
- br_target = 0x3002 -> if_adel = 1 for that PC; XLEN = 16 instance at pc = 0xFFFC -> pc wraps to 0x0000.
